// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT receive path: parity modes, rx state
// encoding and the default frame width.
package usrt_pkg;

   localparam int DATA_BITS_DEF = 8;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DATA    = 3'd1,
      PARITY  = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } rx_state_t;

   // Mode 2'b11 behaves like "none": no parity bit on the line.
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/usrt_rx_shift.sv
// Receive datapath: LSB-first shift register, data-bit counter and running
// XOR of the data bits, stepped by clear/shift enables from the sequencer.
module usrt_rx_shift
   import usrt_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                 i_Pclk,
   input  logic                 i_Rst,
   input  logic                 clr,
   input  logic                 shift,
   input  logic                 bit_in,
   output logic [DATA_BITS-1:0] data,
   output logic                 last,
   output logic                 acc
);

   localparam int CW = $clog2(DATA_BITS + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) begin
         cnt  <= '0;
         data <= '0;
         acc  <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         data <= '0;
         acc  <= 1'b0;
      end else if (shift) begin
         // New bits enter at the MSB so the first bit received ends up in bit 0.
         data <= {bit_in, data[DATA_BITS-1:1]};
         acc  <= acc ^ bit_in;
         cnt  <= cnt + 1'b1;
      end
   end

   assign last = (cnt == CW'(DATA_BITS - 1));

endmodule

// File: rtl/usrt_rx_ctrl.sv
// USRT receive sequencer: start detection, data/parity/stop stepping with
// on-the-fly parity and framing checks, and a one-entry valid/ready buffer.
//
//   state   | meaning
//   IDLE    | line idle, waiting for a strobe that samples a 0 start bit
//   DATA    | shifting DATA_BITS data bits, LSB first
//   PARITY  | sampling the parity bit (only when the latched mode has parity)
//   STOP    | sampling the stop bit; the frame is committed on this strobe
//   WAIT_HI | after a framing error, waiting for the line to return high
module usrt_rx_ctrl
   import usrt_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                 i_Pclk,
   input  logic                 i_Rst,
   input  logic                 i_BitEn,
   input  logic                 i_Rx,
   input  logic [1:0]           i_Parity,
   input  logic                 i_Ready,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Valid,
   output logic                 o_ParErr,
   output logic                 o_FrmErr,
   output logic                 o_Overrun,
   output logic                 o_Busy
);

   rx_state_t state;
   logic [1:0] mode;
   logic       perr_q;

   logic                 start_det;
   logic                 shift_en;
   logic [DATA_BITS-1:0] sh_data;
   logic                 sh_last;
   logic                 sh_acc;
   logic                 buf_free;

   assign start_det = (state == IDLE) && i_BitEn && !i_Rx;
   assign shift_en  = (state == DATA) && i_BitEn;
   assign buf_free  = !o_Valid || i_Ready;

   usrt_rx_shift #(
      .DATA_BITS (DATA_BITS)
   ) u_shift (
      .i_Pclk (i_Pclk),
      .i_Rst  (i_Rst),
      .clr    (start_det),
      .shift  (shift_en),
      .bit_in (i_Rx),
      .data   (sh_data),
      .last   (sh_last),
      .acc    (sh_acc)
   );

   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) begin
         state     <= IDLE;
         mode      <= PAR_NONE;
         perr_q    <= 1'b0;
         o_Data    <= '0;
         o_Valid   <= 1'b0;
         o_ParErr  <= 1'b0;
         o_FrmErr  <= 1'b0;
         o_Overrun <= 1'b0;
         o_Busy    <= 1'b0;
      end else begin
         o_Overrun <= 1'b0;
         // Consumption; a commit later in this block overrides it.
         if (o_Valid && i_Ready)
            o_Valid <= 1'b0;

         if (i_BitEn) begin
            case (state)
               IDLE: begin
                  if (!i_Rx) begin
                     state  <= DATA;
                     mode   <= i_Parity;
                     perr_q <= 1'b0;
                     o_Busy <= 1'b1;
                  end
               end
               DATA: begin
                  if (sh_last)
                     state <= par_enabled(mode) ? PARITY : STOP;
               end
               PARITY: begin
                  perr_q <= sh_acc ^ i_Rx ^ (mode == PAR_ODD);
                  state  <= STOP;
               end
               STOP: begin
                  if (buf_free) begin
                     o_Data   <= sh_data;
                     o_ParErr <= perr_q;
                     o_FrmErr <= !i_Rx;
                     o_Valid  <= 1'b1;
                  end else begin
                     o_Overrun <= 1'b1;
                  end
                  if (i_Rx) begin
                     state  <= IDLE;
                     o_Busy <= 1'b0;
                  end else begin
                     state <= WAIT_HI;
                  end
               end
               WAIT_HI: begin
                  // A low line here is a break, not a new start bit.
                  if (i_Rx) begin
                     state  <= IDLE;
                     o_Busy <= 1'b0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// Self-checking bench for usrt_rx_ctrl: frames are built from data/mode
// arithmetic and the delivered buffer is compared against a frame-level model.
module tb_usrt_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_en = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] parity = 2'b00;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, par_err, frm_err, overrun, busy;

   int errors = 0;
   int checks = 0;
   int ovr_cnt = 0;
   int stall_viol = 0;

   logic [7:0] exp_data = 8'h00;
   logic       exp_valid = 1'b0;
   logic       exp_perr = 1'b0;
   logic       exp_ferr = 1'b0;
   int         exp_ovr = 0;

   usrt_rx_ctrl #(.DATA_BITS(8)) dut (
      .i_Pclk    (clk),
      .i_Rst     (rst),
      .i_BitEn   (bit_en),
      .i_Rx      (rx),
      .i_Parity  (parity),
      .i_Ready   (ready),
      .o_Data    (data),
      .o_Valid   (valid),
      .o_ParErr  (par_err),
      .o_FrmErr  (frm_err),
      .o_Overrun (overrun),
      .o_Busy    (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (overrun) ovr_cnt++;

   // Parity bit a correct transmitter would send for this data and mode.
   function automatic logic good_par(input logic [7:0] d, input logic [1:0] m);
      return (m == 2'b01) ? ^d : ~^d;
   endfunction

   function automatic logic has_par(input logic [1:0] m);
      return (m == 2'b01) || (m == 2'b10);
   endfunction

   task automatic model_commit(input logic [7:0] d, input logic [1:0] m,
                               input logic pbit, input logic stop, input logic rdy);
      logic perr;
      perr = has_par(m) ? (pbit != good_par(d, m)) : 1'b0;
      if (!exp_valid || rdy) begin
         exp_data  = d;
         exp_perr  = perr;
         exp_ferr  = !stop;
         exp_valid = 1'b1;
      end else begin
         exp_ovr++;
      end
   endtask

   task automatic drive_bit(input logic b, input int div);
      logic [8:0] snap;
      snap = {busy, data};
      for (int i = 0; i < div; i++) begin
         rx = b;
         bit_en = (i == div - 1);
         @(posedge clk); #1;
         if (i != div - 1 && {busy, data} !== snap) stall_viol++;
      end
      bit_en = 1'b0;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      bit_en = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
      bit_en = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] m, input logic pbit,
                             input logic stop, input logic rdy_stop, input int div,
                             input logic [1:0] m_after);
      parity = m;
      drive_bit(1'b0, div);
      parity = m_after;
      for (int i = 0; i < 8; i++) drive_bit(d[i], div);
      if (has_par(m)) drive_bit(pbit, div);
      ready = rdy_stop;
      drive_bit(stop, div);
      ready = 1'b0;
      model_commit(d, m, pbit, stop, rdy_stop);
   endtask

   task automatic consume();
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      exp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({valid, par_err, frm_err, overrun, busy, data} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b pe=%b fe=%b ov=%b busy=%b data=%h, expected all 0",
                  valid, par_err, frm_err, overrun, busy, data);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_even();
      send_frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b0, 1, 2'b01);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL even_a5: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL even_busy_after_stop: got %b expected 0", busy);
      end
      consume();
      checks++;
      if ({valid, data} !== {1'b0, 8'hA5}) begin
         errors++;
         $display("FAIL even_consume: got v=%b d=%h expected v=0 d=a5", valid, data);
      end
   endtask

   task automatic test_odd_none();
      send_frame(8'hA5, 2'b10, 1'b0, 1'b1, 1'b0, 1, 2'b10);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL odd_bad_par: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
      send_frame(8'hA5, 2'b10, 1'b1, 1'b1, 1'b0, 1, 2'b10);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL odd_good_par: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
      send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0, 1, 2'b00);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL none_3c: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
   endtask

   task automatic test_break();
      int spurious;
      spurious = 0;
      send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b0, 1, 2'b00);
      checks++;
      if ({valid, par_err, frm_err, data, busy} !== {exp_valid, exp_perr, exp_ferr, exp_data, 1'b1}) begin
         errors++;
         $display("FAIL break_frame: got v=%b pe=%b fe=%b d=%h busy=%b, expected v=%b pe=%b fe=%b d=%h busy=1",
                  valid, par_err, frm_err, data, busy, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
      for (int i = 0; i < 20; i++) begin
         drive_bit(1'b0, 1);
         if (valid !== 1'b0 || busy !== 1'b1) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL break_hold: got %0d bad cycles expected 0", spurious);
      end
      drive_bit(1'b1, 1);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL break_release: got busy=%b expected 0", busy);
      end
      send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1, 2'b00);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL break_next_5a: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int base;
      base = ovr_cnt;
      send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b0, 1, 2'b00);
      send_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b0, 1, 2'b00);
      idle(3);
      checks++;
      if ({valid, data} !== {exp_valid, exp_data}) begin
         errors++;
         $display("FAIL b2b_retain: got v=%b d=%h expected v=%b d=%h", valid, data, exp_valid, exp_data);
      end
      checks++;
      if (ovr_cnt - base != exp_ovr) begin
         errors++;
         $display("FAIL b2b_overrun: got %0d pulse cycles expected %0d", ovr_cnt - base, exp_ovr);
      end
      send_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b1, 1, 2'b00);
      idle(2);
      checks++;
      if ({valid, data} !== {exp_valid, exp_data} || ovr_cnt - base != exp_ovr) begin
         errors++;
         $display("FAIL b2b_ready_commit: got v=%b d=%h ovr=%0d expected v=%b d=%h ovr=%0d",
                  valid, data, ovr_cnt - base, exp_valid, exp_data, exp_ovr);
      end
      consume();
      exp_ovr = 0;
   endtask

   task automatic test_reset_mid();
      send_frame(8'h77, 2'b00, 1'b0, 1'b1, 1'b0, 1, 2'b00);
      parity = 2'b00;
      drive_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1);
      rst = 1'b1;
      #1;
      checks++;
      if ({valid, par_err, frm_err, overrun, busy, data} !== 13'h0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b pe=%b fe=%b ov=%b busy=%b d=%h expected all 0",
                  valid, par_err, frm_err, overrun, busy, data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_valid = 1'b0;
      exp_data = 8'h00;
      exp_perr = 1'b0;
      exp_ferr = 1'b0;
      idle(2);
      send_frame(8'hC3, 2'b01, 1'b0, 1'b1, 1'b0, 1, 2'b01);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL reset_then_c3: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
   endtask

   task automatic test_bit_enable();
      logic [7:0] d;
      stall_viol = 0;
      d = 8'($urandom);
      // Correct odd parity; would be wrong if the switched-to even mode were used.
      send_frame(d, 2'b10, good_par(d, 2'b10), 1'b1, 1'b0, 3, 2'b01);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL latch_odd: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
      d = 8'($urandom);
      send_frame(d, 2'b01, ~good_par(d, 2'b01), 1'b1, 1'b0, 3, 2'b00);
      checks++;
      if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
         errors++;
         $display("FAIL latch_even: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                  valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
      end
      consume();
      checks++;
      if (stall_viol != 0) begin
         errors++;
         $display("FAIL no_strobe_stall: got %0d changes expected 0", stall_viol);
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [1:0] m;
      logic       pbit, stop, rdy;
      int         div, base, bad;
      base = ovr_cnt;
      exp_ovr = 0;
      bad = 0;
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         m    = 2'($urandom_range(0, 3));
         pbit = 1'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         rdy  = 1'($urandom);
         div  = $urandom_range(1, 3);
         send_frame(d, m, pbit, stop, rdy, div, 2'($urandom));
         checks++;
         if ({valid, par_err, frm_err, data} !== {exp_valid, exp_perr, exp_ferr, exp_data}) begin
            errors++;
            $display("FAIL random_frame_%0d: got v=%b pe=%b fe=%b d=%h, expected v=%b pe=%b fe=%b d=%h",
                     n, valid, par_err, frm_err, data, exp_valid, exp_perr, exp_ferr, exp_data);
         end
         if (!stop) drive_bit(1'b1, div);
         idle(1);
         if (ovr_cnt - base != exp_ovr) bad++;
         if ($urandom_range(0, 2) == 0) consume();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL random_overrun: got %0d pulses expected %0d", ovr_cnt - base, exp_ovr);
      end
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd_none();
      test_break();
      test_back_to_back();
      test_reset_mid();
      test_bit_enable();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
